// File: rtl/vga_timing_gen.sv
// Parametrised VGA/HDMI raster timing generator.
// Free-running h/v counters gated by en. Every output is a combinational
// decode of the counter registers and en. The pixel request runs REQ_LAT
// clocks ahead of de, so a source with that latency can supply data in time.
module vga_timing_gen #(
  parameter int                H_SYNC     = 96,
  parameter int                H_BACK     = 40,
  parameter int                H_LEFT     = 8,
  parameter int                H_VALID    = 640,
  parameter int                H_RIGHT    = 8,
  parameter int                H_FRONT    = 8,
  parameter int                V_SYNC     = 2,
  parameter int                V_BACK     = 25,
  parameter int                V_TOP      = 8,
  parameter int                V_VALID    = 480,
  parameter int                V_BOTTOM   = 8,
  parameter int                V_FRONT    = 2,
  parameter int                CNT_W      = 12,
  parameter int                PIX_W      = 16,
  parameter int                REQ_LAT    = 1,
  parameter logic              HS_POL     = 1'b1,
  parameter logic              VS_POL     = 1'b1,
  parameter logic [PIX_W-1:0]  BORDER_RGB = '0,
  parameter int                FRAME_W    = 16
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PIX_W-1:0]   pix_data,
  output logic [PIX_W-1:0]   vga_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               pix_req,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK + H_LEFT;
  localparam int VA      = V_SYNC + V_BACK + V_TOP;

  // Region bounds as counter-width constants (half-open intervals [lo, hi)).
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DE_H0  = CNT_W'(HA);
  localparam logic [CNT_W-1:0] DE_H1  = CNT_W'(HA + H_VALID);
  localparam logic [CNT_W-1:0] DE_V0  = CNT_W'(VA);
  localparam logic [CNT_W-1:0] DE_V1  = CNT_W'(VA + V_VALID);
  localparam logic [CNT_W-1:0] BD_H0  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] BD_H1  = CNT_W'(HA + H_VALID + H_RIGHT);
  localparam logic [CNT_W-1:0] BD_V0  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] BD_V1  = CNT_W'(VA + V_VALID + V_BOTTOM);
  localparam logic [CNT_W-1:0] RQ_H0  = CNT_W'(HA - REQ_LAT);
  localparam logic [CNT_W-1:0] RQ_H1  = CNT_W'(HA + H_VALID - REQ_LAT);

  // Reject geometries the counters cannot represent or a lead time that
  // would start requests before the line does.
  generate
    if ((H_TOTAL >> CNT_W) != 0 || (V_TOTAL >> CNT_W) != 0) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (REQ_LAT < 0 || REQ_LAT > HA) begin : g_bad_lat
      $error("vga_timing_gen: REQ_LAT must lie in 0..HA");
    end
  endgenerate

  logic [CNT_W-1:0]   cnt_h_reg, cnt_h_next;
  logic [CNT_W-1:0]   cnt_v_reg, cnt_v_next;
  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;

  // Next-state: count while enabled, park at the origin while disabled.
  always_comb begin
    cnt_h_next     = cnt_h_reg;
    cnt_v_next     = cnt_v_reg;
    frame_cnt_next = frame_cnt_reg;
    if (!en) begin
      cnt_h_next = '0;
      cnt_v_next = '0;
    end else if (cnt_h_reg == H_LAST) begin
      cnt_h_next = '0;
      if (cnt_v_reg == V_LAST) begin
        cnt_v_next     = '0;
        frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
      end else begin
        cnt_v_next = cnt_v_reg + CNT_W'(1);
      end
    end else begin
      cnt_h_next = cnt_h_reg + CNT_W'(1);
    end
  end

  // State registers; reset clears counters and the frame count at once.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_reg     <= '0;
      cnt_v_reg     <= '0;
      frame_cnt_reg <= '0;
    end else begin
      cnt_h_reg     <= cnt_h_next;
      cnt_v_reg     <= cnt_v_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  logic h_de, v_de, h_bd, v_bd, h_rq, de_int, bd_int, rq_int;

  // Output decode: region tests, then gate everything with en.
  always_comb begin
    h_de   = (cnt_h_reg >= DE_H0) && (cnt_h_reg < DE_H1);
    v_de   = (cnt_v_reg >= DE_V0) && (cnt_v_reg < DE_V1);
    h_bd   = (cnt_h_reg >= BD_H0) && (cnt_h_reg < BD_H1);
    v_bd   = (cnt_v_reg >= BD_V0) && (cnt_v_reg < BD_V1);
    h_rq   = (cnt_h_reg >= RQ_H0) && (cnt_h_reg < RQ_H1);
    de_int = en && h_de && v_de;
    bd_int = en && h_bd && v_bd && !de_int;
    rq_int = en && h_rq && v_de;

    hsync       = (en && (cnt_h_reg < HS_END)) ? HS_POL : ~HS_POL;
    vsync       = (en && (cnt_v_reg < VS_END)) ? VS_POL : ~VS_POL;
    de          = de_int;
    pix_req     = rq_int;
    pix_x       = '1;
    pix_y       = '1;
    if (rq_int) begin
      pix_x = cnt_h_reg - RQ_H0;
      pix_y = cnt_v_reg - DE_V0;
    end
    vga_rgb     = '0;
    if (de_int)      vga_rgb = pix_data;
    else if (bd_int) vga_rgb = BORDER_RGB;
    line_start  = en && (cnt_h_reg == '0);
    frame_start = en && (cnt_h_reg == '0) && (cnt_v_reg == '0);
    frame_cnt   = frame_cnt_reg;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/HDMI raster timing generator; successor to the fixed 640x480 controller.
- Horizontal and vertical timing, sync polarity, border colour, pixel-fetch lead time, data width and enable gating are all configurable.
- Sits between the pixel source (pattern generator or frame buffer reader) and the TMDS encoder / VGA DAC.
- Adds frame/line start strobes, a frame counter and a run-enable that the previous controller did not have.

Parameters:
- H_SYNC, 96, hsync width in clocks
- H_BACK, 40, horizontal back porch
- H_LEFT, 8, left border
- H_VALID, 640, active pixels per line
- H_RIGHT, 8, right border
- H_FRONT, 8, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 25, vertical back porch
- V_TOP, 8, top border
- V_VALID, 480, active lines
- V_BOTTOM, 8, bottom border
- V_FRONT, 2, vertical front porch
- CNT_W, 12, width of the h/v counters and pix_x/pix_y
- PIX_W, 16, pixel data width
- REQ_LAT, 1, clocks between pix_x/pix_y request and pix_data return; range 0..H_SYNC+H_BACK+H_LEFT
- HS_POL, 1, active level of hsync
- VS_POL, 1, active level of vsync
- BORDER_RGB, 0, colour driven in border region (PIX_W bits)
- FRAME_W, 16, frame counter width

Ports:
- vga_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable
- pix_data  in  PIX_W  pixel for the coordinate requested REQ_LAT clocks earlier
- vga_rgb  out  PIX_W  pixel to encoder
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  active-video data enable
- pix_req  out  1  pix_x/pix_y valid
- pix_x  out  CNT_W  requested column; all-ones when pix_req=0
- pix_y  out  CNT_W  requested row; all-ones when pix_req=0
- line_start  out  1  one-clock pulse at cnt_h=0
- frame_start  out  1  one-clock pulse at cnt_h=0, cnt_v=0
- frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
- Derived constants:
  - H_TOTAL = sum of all H_* parameters; V_TOTAL likewise.
  - HA = H_SYNC+H_BACK+H_LEFT; VA = V_SYNC+V_BACK+V_TOP.
  - Region bounds: HB0 = H_SYNC+H_BACK, HB1 = HA+H_VALID+H_RIGHT; VB0 and VB1 analogous.
- Counters cnt_h, cnt_v are internal CNT_W registers, reset to 0.
  - When en=1: cnt_h increments each clock and wraps H_TOTAL-1 -> 0. cnt_v increments when cnt_h wraps, and wraps V_TOTAL-1 -> 0.
  - When en=0: both counters load 0 at the next edge and hold there.
  - After en rises, the first enabled clock presents cnt_h=0, cnt_v=0.
- All outputs are combinational decodes of the counter registers and en. There are no extra pipeline stages.
- hsync is active (HS_POL) when cnt_h < H_SYNC; vsync is active (VS_POL) when cnt_v < V_SYNC. Both are otherwise at the inactive level.
- de = (HA <= cnt_h < HA+H_VALID) and (VA <= cnt_v < VA+V_VALID).
- border = (HB0 <= cnt_h < HB1) and (VB0 <= cnt_v < VB1), and not de.
- vga_rgb:
  - pix_data when de=1;
  - BORDER_RGB when border=1;
  - 0 otherwise.
- pix_req = (HA-REQ_LAT <= cnt_h < HA+H_VALID-REQ_LAT) and (VA <= cnt_v < VA+V_VALID).
  - When pix_req=1: pix_x = cnt_h-(HA-REQ_LAT) and pix_y = cnt_v-VA.
  - REQ_LAT=0 makes pix_req identical to de.
- line_start = (cnt_h==0); frame_start = (cnt_h==0 and cnt_v==0). Both are qualified by en.
- frame_cnt increments on the edge where cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1 while en=1. It wraps modulo 2^FRAME_W and holds its value when en=0.
- en=0:
  - hsync and vsync are at their inactive levels;
  - de, pix_req, line_start and frame_start are 0;
  - vga_rgb is 0;
  - pix_x and pix_y are all-ones.
- Reset (rst_n=0, asynchronous, including mid-frame):
  - counters and frame_cnt clear immediately;
  - outputs then take the decoded values for cnt=0: with en=1, hsync and vsync are active, de=0, vga_rgb=0, pix_x and pix_y are all-ones.
- en deasserted mid-line truncates the frame; frame_cnt does not count it.
- Elaboration: H_TOTAL and V_TOTAL must be below 2^CNT_W, and REQ_LAT must not exceed HA. Violating either is an elaboration error.

Test Plan:
- Defaults, en=1 from reset, run 2 frames:
  - hsync high for cnt_h 0..95, period 800 clocks;
  - vsync high for 2 lines, period 420000 clocks;
  - de high for 640 clocks per line on 480 lines;
  - frame_cnt = 2.
- Defaults, REQ_LAT=1, line cnt_v=35:
  - pix_req first asserts at cnt_h=143 with pix_x=0, pix_y=0;
  - last assertion at cnt_h=782 with pix_x=639;
  - de spans cnt_h 144..783;
  - with pix_data = pix_x registered, vga_rgb equals the column index.
- Border: BORDER_RGB=16'hF800 on line cnt_v=35:
  - vga_rgb = F800 for cnt_h 136..143 and 784..791;
  - vga_rgb = 0 for cnt_h 0..135;
  - on line cnt_v=27 (top border), vga_rgb = F800 for cnt_h 136..791.
- Polarity and latency: HS_POL=0, VS_POL=0, REQ_LAT=3:
  - hsync low for cnt_h 0..95, vsync low for cnt_v 0..1;
  - pix_req rises at cnt_h=141.
- Enable: drop en at cnt_h=300, cnt_v=100 for 10 clocks, then raise it:
  - all outputs idle during the gap;
  - frame_start pulses on the first clock after en rises;
  - frame_cnt unchanged.
- Reset mid-frame: assert rst_n=0 at cnt_v=200:
  - frame_cnt=0 and de=0 immediately;
  - after release, frame_start pulses on the first clock and the line period is 800.
